// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the memory port arbiter.
// Requesters hold req and payload stable until their done pulse; memory holds nothing, it answers mem_req with a one-cycle mem_ack.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_done;
  logic [63:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic        mem_wide;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        arb_err;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output if_done, if_rdata, dm_done, dm_rdata, mem_req, mem_we, mem_wide, mem_addr,
           mem_wdata, arb_err
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  if_done, if_rdata, dm_done, dm_rdata, mem_req, mem_we, mem_wide, mem_addr,
           mem_wdata, arb_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch and the MEM stage, data first,
// with a starvation guard for fetch and a sticky timeout error for lost acks.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.master   bus,
  output logic [1:0]           dbg_state
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_DM = 2'd2;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic          fetch_forced;
  logic          grant_dm;
  logic          finish;
  logic          unused_addr_hi;

  assign dbg_state      = state;
  assign unused_addr_hi = ^bus.if_addr[63:32];

  // Fetch only pre-empts data once it has lost STARVE_LIMIT grants in a row.
  assign fetch_forced = bus.if_req && (starve_cnt == SW'(STARVE_LIMIT));
  assign grant_dm     = bus.dm_req && !fetch_forced;
  // An ack on the last allowed cycle still counts as a normal completion.
  assign finish       = bus.mem_ack || (wait_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      wait_cnt      <= '0;
      bus.if_done   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_done   <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wide  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.arb_err   <= 1'b0;
    end else begin
      bus.if_done <= 1'b0;
      bus.dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state         <= BUSY_DM;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_wide  <= 1'b1;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            wait_cnt      <= '0;
            if (!bus.if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (bus.if_req) begin
            state         <= BUSY_IF;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_wide  <= 1'b0;
            bus.mem_addr  <= bus.if_addr[31:0];
            bus.mem_wdata <= '0;
            wait_cnt      <= '0;
            starve_cnt    <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (finish) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            if (!bus.mem_ack) begin
              bus.arb_err <= 1'b1;
            end
            // Aborted accesses still complete towards the requester, with zero data.
            if (state == BUSY_IF) begin
              bus.if_done  <= 1'b1;
              bus.if_rdata <= bus.mem_ack ? bus.mem_rdata[31:0] : 32'h0;
            end else begin
              bus.dm_done  <= 1'b1;
              bus.dm_rdata <= bus.mem_ack ? bus.mem_rdata : 64'h0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small word memory with programmable ack latency,
// a result queue filled when requests are driven and drained on done pulses.
module tb_mem_port_arbiter;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  bit          chk_q[$];
  logic        grant_q[$];

  // Memory model: 16 doublewords, ack after ack_lat cycles of mem_req (or never).
  logic [63:0] mem_arr [16];
  int          mem_cnt;
  int          ack_lat;
  bit          ack_on;
  bit          log_en;
  logic        req_d;

  function automatic logic [63:0] init_word(input int i);
    return {32'h1234_0000 + 32'(i), 32'hC800_0000 + 32'(i)};
  endfunction

  assign bus.mem_ack   = bus.mem_req && ack_on && (mem_cnt == ack_lat);
  assign bus.mem_rdata = bus.mem_ack ? mem_arr[bus.mem_addr[6:3]] : 64'h0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
    end else if (bus.mem_ack && bus.mem_we) begin
      mem_arr[bus.mem_addr[6:3]] <= bus.mem_wdata;
    end
    mem_cnt <= bus.mem_req ? mem_cnt + 1 : 0;
  end

  always @(negedge clk) begin
    if (log_en && bus.mem_req && !req_d) grant_q.push_back(bus.mem_wide);
    req_d <= bus.mem_req;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          obs_lat;
  int          obs_req_cycles;
  logic        obs_we_any;
  logic        obs_wide;
  logic [31:0] obs_addr;

  task automatic drop_reqs();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drop_reqs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Issues one access from a negedge and waits (bounded) for its done pulse.
  task automatic run_access(input bit is_dm, input bit we, input logic [31:0] addr,
                            input logic [63:0] wdata, input bit chk, input logic [63:0] exp,
                            input string tag);
    bit          seen;
    bit          c;
    logic [63:0] e;
    logic [63:0] rd;
    seen = 1'b0;
    obs_lat = 0; obs_req_cycles = 0; obs_we_any = 1'b0; obs_wide = 1'b0; obs_addr = '0;
    exp_q.push_back(exp);
    chk_q.push_back(chk);
    if (is_dm) begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = {32'h0, addr};
    end
    for (int n = 1; n <= 64 && !seen; n++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (obs_req_cycles == 0) begin
          obs_wide = bus.mem_wide;
          obs_addr = bus.mem_addr;
        end
        obs_req_cycles++;
        obs_we_any = obs_we_any | bus.mem_we;
      end
      if (is_dm ? bus.if_done : bus.dm_done) check({tag, "_stray_done"}, 1, 0);
      if (is_dm ? bus.dm_done : bus.if_done) begin
        seen = 1'b1;
        obs_lat = n;
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        rd = is_dm ? bus.dm_rdata : {32'h0, bus.if_rdata};
        if (c) check({tag, "_rdata"}, rd, e);
        drop_reqs();
      end
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
      drop_reqs();
      void'(exp_q.pop_front());
      void'(chk_q.pop_front());
    end
  endtask

  logic [63:0] w;
  logic        exp_order [10];
  bit          dm_done_seen;

  initial begin
    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    ack_on = 1'b1; ack_lat = 1; log_en = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_if_done", bus.if_done, 0);
    check("rst_dm_done", bus.dm_done, 0);
    check("rst_arb_err", bus.arb_err, 0);
    check("rst_state", dbg_state, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    do_reset();

    // 1: single fetch, ack one cycle after mem_req
    w = init_word(0);
    run_access(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, {32'h0, w[31:0]}, "t1");
    check("t1_latency", obs_lat, 3);
    check("t1_wide", obs_wide, 0);
    check("t1_we", obs_we_any, 0);

    // 2: store then load at 0x80000-8, zero-wait memory
    ack_lat = 0;
    run_access(1'b1, 1'b1, 32'h0008_0000 - 32'd8, 64'h2004, 1'b0, 64'h0, "t2_st");
    check("t2_st_we", obs_we_any, 1);
    check("t2_st_wide", obs_wide, 1);
    check("t2_st_latency", obs_lat, 2);
    run_access(1'b1, 1'b0, 32'h0008_0000 - 32'd8, 64'h0, 1'b1, 64'h2004, "t2_ld");
    check("t2_ld_we", obs_we_any, 0);
    check("t2_ld_addr", obs_addr, 32'h0007_FFF8);

    // 3: both requesters held high; expect D,D,D,D,I,D,D,D,D,I
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    log_en = 1'b1;
    bus.dm_we = 1'b0; bus.dm_addr = 32'd8; bus.if_addr = 64'd16;
    bus.dm_req = 1'b1; bus.if_req = 1'b1;
    for (int n = 0; n < 200 && grant_q.size() < 10; n++) begin
      @(negedge clk);
      #1;
    end
    drop_reqs();
    log_en = 1'b0;
    repeat (6) @(negedge clk);
    check("t3_grant_count", grant_q.size(), 10);
    for (int i = 0; i < 10 && i < grant_q.size(); i++) begin
      check($sformatf("t3_grant_%0d", i), grant_q[i], exp_order[i]);
    end

    // 4: fetch never acked -> abort after 16 cycles, sticky error
    ack_on = 1'b0;
    run_access(1'b0, 1'b0, 32'd8, 64'h0, 1'b1, 64'h0, "t4");
    check("t4_req_cycles", obs_req_cycles, 16);
    check("t4_latency", obs_lat, 17);
    check("t4_arb_err", bus.arb_err, 1);
    ack_on = 1'b1; ack_lat = 0;
    run_access(1'b1, 1'b0, 32'd24, 64'h0, 1'b1, init_word(3), "t4_after");
    check("t4_arb_err_sticky", bus.arb_err, 1);

    // 5: reset mid data access
    ack_on = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'd40;
    repeat (3) @(negedge clk);
    check("t5_busy_req", bus.mem_req, 1);
    check("t5_busy_state", dbg_state, 2);
    #2 reset = 1'b0;
    #1;
    check("t5_async_mem_req", bus.mem_req, 0);
    check("t5_async_mem_addr", bus.mem_addr, 0);
    check("t5_async_wide", bus.mem_wide, 0);
    check("t5_async_dm_rdata", bus.dm_rdata, 0);
    check("t5_async_arb_err", bus.arb_err, 0);
    check("t5_async_state", dbg_state, 0);
    dm_done_seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      dm_done_seen = dm_done_seen | bus.dm_done;
    end
    drop_reqs();
    reset = 1'b1;
    ack_on = 1'b1;
    @(negedge clk);
    dm_done_seen = dm_done_seen | bus.dm_done;
    check("t5_no_done", dm_done_seen, 0);
    run_access(1'b1, 1'b0, 32'd40, 64'h0, 1'b1, init_word(5), "t5_after");
    check("t5_after_latency", obs_lat, 2);

    // 6: ack on exactly the timeout cycle completes normally
    ack_lat = 15;
    w = init_word(2);
    run_access(1'b0, 1'b0, 32'd16, 64'h0, 1'b1, {32'h0, w[31:0]}, "t6");
    check("t6_latency", obs_lat, 17);
    check("t6_req_cycles", obs_req_cycles, 16);
    check("t6_arb_err", bus.arb_err, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
